// File: rtl/clock_time_counter_pkg.sv
// Shared time constants and BCD helpers for the clock_time_counter block.
// No logic of its own; imported by the counter modules.
package clock_defs;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } time_t;

  localparam logic [7:0] SEC_MIN_WRAP = 8'h59;
  localparam logic [7:0] HOUR24_MAX   = 8'h23;
  localparam logic [7:0] HOUR12_MIN   = 8'h01;
  localparam logic [7:0] HOUR12_MAX   = 8'h12;
  localparam logic [7:0] RST_HOUR_24  = 8'h00;
  localparam logic [7:0] RST_HOUR_12  = 8'h12;
  localparam logic [7:0] RST_MIN      = 8'h00;
  localparam logic [7:0] RST_SEC      = 8'h00;

  // Two-digit BCD +1 without wrap; callers handle their own limits.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hour_next(input logic [7:0] h, input logic mode24);
    if (mode24) return (h == HOUR24_MAX) ? 8'h00 : bcd_inc(h);
    return (h == HOUR12_MAX) ? HOUR12_MIN : bcd_inc(h);
  endfunction

  function automatic time_t reset_time(input logic mode24);
    return '{hour: (mode24 ? RST_HOUR_24 : RST_HOUR_12), min: RST_MIN, sec: RST_SEC};
  endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD 00..59 counter with clear (priority) and increment.
// Latency: value updates on the enabling edge; carry is combinational from inc and value.
// Backpressure: none, inc is a single-cycle request that is always accepted.
module bcd_mod60_counter
  import clock_defs::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  assign carry = inc && !clr && (value == SEC_MIN_WRAP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= RESET_VAL;
    end else if (clr) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= (value == SEC_MIN_WRAP) ? 8'h00 : bcd_inc(value);
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// BCD time-of-day counter (24 h or 12 h) advanced by 1 Hz edges, with a button set mode.
// Latency: all outputs registered; they change on the edge where the input edge is detected.
// Backpressure: none, ticks and button edges are consumed or dropped in the same cycle.
module clock_time_counter
  import clock_defs::*;
#(
  parameter int MODE_24H = 1
) (
  input  logic       in_50MHz,
  input  logic       rst_n,
  input  logic       in_1Hz,
  input  logic       set_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       sec_pulse
);

  localparam logic  MODE24   = (MODE_24H != 0);
  localparam time_t RST_TIME = reset_time(MODE24);

  logic tick_q, hbtn_q, mbtn_q;
  logic tick_edge, hbtn_edge, mbtn_edge;
  logic sec_inc, min_inc, hour_inc;
  logic sec_carry, min_carry;

  // Edge registers reset high so inputs already high at release are not edges.
  always_ff @(posedge in_50MHz) begin
    if (!rst_n) begin
      tick_q <= 1'b1;
      hbtn_q <= 1'b1;
      mbtn_q <= 1'b1;
    end else begin
      tick_q <= in_1Hz;
      hbtn_q <= btn_hour;
      mbtn_q <= btn_min;
    end
  end

  assign tick_edge = in_1Hz & ~tick_q;
  assign hbtn_edge = btn_hour & ~hbtn_q;
  assign mbtn_edge = btn_min & ~mbtn_q;

  // Set mode swaps the carry chain for the buttons; buttons never carry.
  assign sec_inc  = tick_edge & ~set_mode;
  assign min_inc  = set_mode ? mbtn_edge : sec_carry;
  assign hour_inc = set_mode ? hbtn_edge : min_carry;

  bcd_mod60_counter #(.RESET_VAL(RST_TIME.sec)) u_sec (
    .clk   (in_50MHz),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (set_mode),
    .value (sec_bcd),
    .carry (sec_carry)
  );

  bcd_mod60_counter #(.RESET_VAL(RST_TIME.min)) u_min (
    .clk   (in_50MHz),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_bcd),
    .carry (min_carry)
  );

  always_ff @(posedge in_50MHz) begin
    if (!rst_n) begin
      hour_bcd  <= RST_TIME.hour;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= sec_inc;
      if (hour_inc) hour_bcd <= hour_next(hour_bcd, MODE24);
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench: one 24 h and one 12 h instance driven by the same stimulus.
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic rst_n, in_1Hz, set_mode, btn_hour, btn_min;
  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic p24, p12;
  int tests = 0;
  int fails = 0;
  int pc24 = 0;
  int pc12 = 0;
  int base24, base12;

  always #10 clk = ~clk;

  clock_time_counter #(.MODE_24H(1)) u24 (
    .in_50MHz(clk), .rst_n(rst_n), .in_1Hz(in_1Hz), .set_mode(set_mode),
    .btn_hour(btn_hour), .btn_min(btn_min),
    .hour_bcd(h24), .min_bcd(m24), .sec_bcd(s24), .sec_pulse(p24)
  );

  clock_time_counter #(.MODE_24H(0)) u12 (
    .in_50MHz(clk), .rst_n(rst_n), .in_1Hz(in_1Hz), .set_mode(set_mode),
    .btn_hour(btn_hour), .btn_min(btn_min),
    .hour_bcd(h12), .min_bcd(m12), .sec_bcd(s12), .sec_pulse(p12)
  );

  always @(negedge clk) begin
    if (p24 === 1'b1) pc24++;
    if (p12 === 1'b1) pc12++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    in_1Hz = 1'b1; step();
    in_1Hz = 1'b0; step();
  endtask

  task automatic press(input bit h, input bit m);
    btn_hour = h; btn_min = m; step();
    btn_hour = 1'b0; btn_min = 1'b0; step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [23:0] e24, input logic [23:0] e12);
    chk({tag, "_24h"}, {8'h00, h24, m24, s24}, {8'h00, e24});
    chk({tag, "_12h"}, {8'h00, h12, m12, s12}, {8'h00, e12});
  endtask

  initial begin
    rst_n = 1'b0; in_1Hz = 1'b1; set_mode = 1'b0; btn_hour = 1'b1; btn_min = 1'b1;
    repeat (3) step();
    chk_all("reset", 24'h000000, 24'h120000);
    chk("reset_pulse", {31'd0, p24 | p12}, 32'd0);

    // release with every input already high
    rst_n = 1'b1;
    repeat (4) step();
    chk_all("release_high", 24'h000000, 24'h120000);
    chk("release_no_pulse", pc24 + pc12, 32'd0);
    in_1Hz = 1'b0; btn_hour = 1'b0; btn_min = 1'b0;
    step();

    // buttons ignored in run mode
    repeat (3) begin
      btn_hour = 1'b1; btn_min = 1'b1; step();
      btn_hour = 1'b0; step();
      btn_min = 1'b0; step();
    end
    chk_all("run_btn_ignored", 24'h000000, 24'h120000);

    base24 = pc24; base12 = pc12;
    repeat (60) tick();
    chk_all("sixty_ticks", 24'h000100, 24'h120100);
    chk("sixty_pulses_24h", pc24 - base24, 32'd60);
    chk("sixty_pulses_12h", pc12 - base12, 32'd60);

    // preset 10:20:35
    set_mode = 1'b1; step();
    repeat (19) press(1'b0, 1'b1);
    repeat (10) press(1'b1, 1'b0);
    set_mode = 1'b0; step();
    repeat (35) tick();
    chk_all("preset_102035", 24'h102035, 24'h102035);

    // set mode entry coincident with a tick
    set_mode = 1'b1; in_1Hz = 1'b1; step();
    chk_all("set_entry_tick", 24'h102000, 24'h102000);
    chk("set_entry_no_pulse", {31'd0, p24 | p12}, 32'd0);
    in_1Hz = 1'b0; step();
    base24 = pc24;
    repeat (2) tick();
    chk_all("set_ticks_ignored", 24'h102000, 24'h102000);
    chk("set_no_pulses", pc24 - base24, 32'd0);

    repeat (13) press(1'b1, 1'b0);
    chk_all("hour_presses", 24'h232000, 24'h112000);
    press(1'b1, 1'b1);
    chk_all("hour_min_pair", 24'h002100, 24'h122100);
    repeat (2) press(1'b0, 1'b1);
    chk_all("set_result", 24'h002300, 24'h122300);
    repeat (36) press(1'b0, 1'b1);
    chk_all("min_at_59", 24'h005900, 24'h125900);
    press(1'b0, 1'b1);
    chk_all("min_wrap_no_carry", 24'h000000, 24'h120000);

    // preset 23:59:59 and roll the day over
    repeat (23) press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    set_mode = 1'b0; step();
    repeat (59) tick();
    chk_all("preset_235959", 24'h235959, 24'h115959);
    base24 = pc24;
    in_1Hz = 1'b1; step();
    chk_all("day_rollover", 24'h000000, 24'h120000);
    chk("rollover_pulse", {31'd0, p24}, 32'd1);
    in_1Hz = 1'b0; step();
    chk("rollover_pulse_one_cycle", {31'd0, p24}, 32'd0);
    chk("rollover_pulse_count", pc24 - base24, 32'd1);

    // 12 h wrap 12:59:59 -> 01:00:00
    set_mode = 1'b1; step();
    repeat (59) press(1'b0, 1'b1);
    set_mode = 1'b0; step();
    repeat (59) tick();
    chk_all("preset_x5959", 24'h005959, 24'h125959);
    tick();
    chk_all("hour12_wrap", 24'h010000, 24'h010000);

    // reset coincident with a carrying tick
    set_mode = 1'b1; step();
    repeat (23) press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    set_mode = 1'b0; step();
    repeat (59) tick();
    chk_all("preset_005959", 24'h005959, 24'h125959);
    rst_n = 1'b0; in_1Hz = 1'b1; step();
    chk_all("reset_on_tick", 24'h000000, 24'h120000);
    chk("reset_on_tick_pulse", {31'd0, p24 | p12}, 32'd0);
    rst_n = 1'b1; step();
    in_1Hz = 1'b0; step();
    chk_all("release_tick_high", 24'h000000, 24'h120000);

    // reset in set mode with a button edge
    set_mode = 1'b1; step();
    btn_min = 1'b1; step();
    chk_all("set_min_press", 24'h000100, 24'h120100);
    btn_min = 1'b0; btn_hour = 1'b1; rst_n = 1'b0; step();
    chk_all("reset_in_set", 24'h000000, 24'h120000);
    rst_n = 1'b1; btn_hour = 1'b0; set_mode = 1'b0; step();
    tick();
    chk_all("resume_after_reset", 24'h000001, 24'h120001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
